// File: rtl/rx_fifo_if.sv
// rx_fifo_if: groups the receiver-side, host-side and status signals of rx_fifo.
//   slave  - used by rx_fifo (consumes receiver/host requests, drives status)
//   master - used by the receiver/host side that drives rx_fifo
// Signals:
//   Rx_Data_In, Data_Rdy_In, Rx_Error_In : from UART receiver
//   Rd_En, Err_Clr                       : from host
//   Rd_Data, Rd_Valid                    : read data path to host
//   Empty, Full, Count, RTS_Out          : occupancy and flow control
//   Err_Status                           : sticky errors [2:0] rx flags, [3] overrun
interface rx_fifo_if #(
  parameter int DATA_BITS = 9,
  parameter int DEPTH     = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_BITS-1:0] Rx_Data_In;
  logic                 Data_Rdy_In;
  logic [2:0]           Rx_Error_In;
  logic                 Rd_En;
  logic [DATA_BITS-1:0] Rd_Data;
  logic                 Rd_Valid;
  logic                 Empty;
  logic                 Full;
  logic [CW-1:0]        Count;
  logic                 RTS_Out;
  logic [3:0]           Err_Status;
  logic                 Err_Clr;

  modport slave (
    input  Rx_Data_In, Data_Rdy_In, Rx_Error_In, Rd_En, Err_Clr,
    output Rd_Data, Rd_Valid, Empty, Full, Count, RTS_Out, Err_Status
  );

  modport master (
    output Rx_Data_In, Data_Rdy_In, Rx_Error_In, Rd_En, Err_Clr,
    input  Rd_Data, Rd_Valid, Empty, Full, Count, RTS_Out, Err_Status
  );
endinterface

// File: rtl/rx_fifo.sv
// rx_fifo: receive buffer behind the UART receiver. Stores one character per
// rising edge of Data_Rdy_In in a circular FIFO, serves host reads with a
// registered data output, drives RTS flow control from occupancy, and keeps
// sticky receive-error / overrun status.
// Ports:
//   Clk - system clock, rising edge
//   Rst - synchronous active-high reset
//   bus - rx_fifo_if.slave (see interface file for signal list)
module rx_fifo #(
  parameter int DATA_BITS    = 9,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic      Clk,
  input  logic      Rst,
  rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_q;
  logic                 data_rdy_d;
  logic [DATA_BITS-1:0] rd_data_q;
  logic                 rd_valid_q;
  logic [3:0]           err_q;

  logic empty;
  logic full;
  logic wr_req;
  logic rd_ok;
  logic wr_ok;
  logic overrun;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign wr_req  = bus.Data_Rdy_In & ~data_rdy_d;
  // Read qualification uses the registered occupancy, so a write landing in
  // the same cycle can never be read straight through.
  assign rd_ok   = bus.Rd_En & ~empty;
  assign wr_ok   = wr_req & (~full | rd_ok);
  assign overrun = wr_req & ~wr_ok;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      data_rdy_d <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      data_rdy_d <= bus.Data_Rdy_In;
      rd_valid_q <= rd_ok;
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (wr_ok && !rd_ok)
        count_q <= count_q + 1'b1;
      else if (rd_ok && !wr_ok)
        count_q <= count_q - 1'b1;
      // A set event in the clearing cycle wins.
      err_q[2:0] <= (err_q[2:0] & ~{3{bus.Err_Clr}}) | bus.Rx_Error_In;
      err_q[3]   <= (err_q[3] & ~bus.Err_Clr) | overrun;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge Clk) begin
    if (!Rst && wr_ok)
      mem[wr_ptr] <= bus.Rx_Data_In;
  end

  assign bus.Rd_Data    = rd_data_q;
  assign bus.Rd_Valid   = rd_valid_q;
  assign bus.Empty      = empty;
  assign bus.Full       = full;
  assign bus.Count      = count_q;
  assign bus.RTS_Out    = (count_q < CW'(DEPTH - AFULL_MARGIN));
  assign bus.Err_Status = err_q;
endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed self-checking bench for rx_fifo.
module tb_rx_fifo;
  localparam int DATA_BITS    = 9;
  localparam int DEPTH        = 16;
  localparam int AFULL_MARGIN = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  rx_fifo_if #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) bus ();

  rx_fifo #(
    .DATA_BITS   (DATA_BITS),
    .DEPTH       (DEPTH),
    .AFULL_MARGIN(AFULL_MARGIN)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_char(input logic [8:0] d);
    bus.Rx_Data_In  = d;
    bus.Data_Rdy_In = 1'b1;
    tick();
    bus.Data_Rdy_In = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    checks++; if (bus.Empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.Empty); end
    checks++; if (bus.Full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.Full); end
    checks++; if (bus.Count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.Count); end
    checks++; if (bus.RTS_Out !== 1'b1) begin failures++; $display("FAIL reset_rts got=%b exp=1", bus.RTS_Out); end
    checks++; if (bus.Err_Status !== 4'b0000) begin failures++; $display("FAIL reset_err got=%b exp=0000", bus.Err_Status); end
    checks++; if (bus.Rd_Valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", bus.Rd_Valid); end
    checks++; if (bus.Rd_Data !== 9'h000) begin failures++; $display("FAIL reset_rd_data got=%h exp=000", bus.Rd_Data); end
    bus.Rd_En = 1'b1;
    tick();
    bus.Rd_En = 1'b0;
    checks++; if (bus.Rd_Valid !== 1'b0) begin failures++; $display("FAIL empty_read_valid got=%b exp=0", bus.Rd_Valid); end
    checks++; if (bus.Count !== 5'd0) begin failures++; $display("FAIL empty_read_count got=%0d exp=0", bus.Count); end
  endtask

  task automatic test_held_level();
    bus.Rx_Data_In  = 9'h0A5;
    bus.Data_Rdy_In = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.Data_Rdy_In = 1'b0;
    tick();
    checks++; if (bus.Count !== 5'd1) begin failures++; $display("FAIL held_count got=%0d exp=1", bus.Count); end
    bus.Rd_En = 1'b1;
    tick();
    bus.Rd_En = 1'b0;
    checks++; if (bus.Rd_Data !== 9'h0A5) begin failures++; $display("FAIL held_rd_data got=%h exp=0a5", bus.Rd_Data); end
    checks++; if (bus.Rd_Valid !== 1'b1) begin failures++; $display("FAIL held_rd_valid got=%b exp=1", bus.Rd_Valid); end
    checks++; if (bus.Empty !== 1'b1) begin failures++; $display("FAIL held_empty got=%b exp=1", bus.Empty); end
    tick();
    checks++; if (bus.Rd_Valid !== 1'b0) begin failures++; $display("FAIL held_valid_drop got=%b exp=0", bus.Rd_Valid); end
  endtask

  task automatic test_fill_wrap();
    logic [8:0] d;
    for (int i = 0; i < 16; i++) begin
      d = 9'(i);
      write_char(d);
      checks++; if (bus.Count !== 5'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.Count, i + 1); end
      checks++; if (bus.RTS_Out !== ((i + 1) < 12)) begin failures++; $display("FAIL fill_rts[%0d] got=%b exp=%b", i, bus.RTS_Out, (i + 1) < 12); end
    end
    checks++; if (bus.Full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", bus.Full); end
    bus.Rd_En = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++; if (bus.Rd_Valid !== 1'b1 || bus.Rd_Data !== 9'(i)) begin failures++; $display("FAIL drain[%0d] got=%h/%b exp=%h/1", i, bus.Rd_Data, bus.Rd_Valid, 9'(i)); end
    end
    bus.Rd_En = 1'b0;
    checks++; if (bus.Empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", bus.Empty); end
    tick();
    checks++; if (bus.Rd_Valid !== 1'b0) begin failures++; $display("FAIL drain_valid_drop got=%b exp=0", bus.Rd_Valid); end
    // two batches of 10: second batch crosses the pointer wrap
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 10; k++) begin
        d = 9'h100 + 9'(b * 10 + k);
        write_char(d);
      end
      checks++; if (bus.Count !== 5'd10) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=10", b, bus.Count); end
      bus.Rd_En = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick();
        d = 9'h100 + 9'(b * 10 + k);
        checks++; if (bus.Rd_Data !== d || bus.Rd_Valid !== 1'b1) begin failures++; $display("FAIL wrap_read[%0d] got=%h/%b exp=%h/1", b * 10 + k, bus.Rd_Data, bus.Rd_Valid, d); end
      end
      bus.Rd_En = 1'b0;
      tick();
    end
    checks++; if (bus.Empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", bus.Empty); end
  endtask

  task automatic test_back_to_back();
    // write and read in the same cycle while empty: no bypass
    bus.Rx_Data_In  = 9'h033;
    bus.Data_Rdy_In = 1'b1;
    bus.Rd_En       = 1'b1;
    tick();
    checks++; if (bus.Rd_Valid !== 1'b0) begin failures++; $display("FAIL no_bypass_valid got=%b exp=0", bus.Rd_Valid); end
    checks++; if (bus.Count !== 5'd1) begin failures++; $display("FAIL no_bypass_count got=%0d exp=1", bus.Count); end
    // fall-through: read in the next cycle returns it
    bus.Data_Rdy_In = 1'b0;
    tick();
    bus.Rd_En = 1'b0;
    checks++; if (bus.Rd_Data !== 9'h033 || bus.Rd_Valid !== 1'b1) begin failures++; $display("FAIL fallthrough got=%h/%b exp=033/1", bus.Rd_Data, bus.Rd_Valid); end
    checks++; if (bus.Empty !== 1'b1) begin failures++; $display("FAIL fallthrough_empty got=%b exp=1", bus.Empty); end
    tick();
  endtask

  task automatic test_overrun();
    logic [8:0] d;
    for (int i = 0; i < 16; i++) begin
      d = 9'h020 + 9'(i);
      write_char(d);
    end
    bus.Rx_Data_In  = 9'h1FF;
    bus.Data_Rdy_In = 1'b1;
    tick();
    bus.Data_Rdy_In = 1'b0;
    checks++; if (bus.Err_Status !== 4'b1000) begin failures++; $display("FAIL overrun_err got=%b exp=1000", bus.Err_Status); end
    checks++; if (bus.Count !== 5'd16) begin failures++; $display("FAIL overrun_count got=%0d exp=16", bus.Count); end
    tick();
    bus.Data_Rdy_In = 1'b1;
    bus.Rd_En       = 1'b1;
    tick();
    bus.Data_Rdy_In = 1'b0;
    bus.Rd_En       = 1'b0;
    checks++; if (bus.Rd_Data !== 9'h020 || bus.Rd_Valid !== 1'b1) begin failures++; $display("FAIL full_rw_data got=%h/%b exp=020/1", bus.Rd_Data, bus.Rd_Valid); end
    checks++; if (bus.Count !== 5'd16) begin failures++; $display("FAIL full_rw_count got=%0d exp=16", bus.Count); end
    bus.Rd_En = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      d = (i < 16) ? 9'h020 + 9'(i) : 9'h1FF;
      checks++; if (bus.Rd_Data !== d) begin failures++; $display("FAIL overrun_drain[%0d] got=%h exp=%h", i, bus.Rd_Data, d); end
    end
    bus.Rd_En = 1'b0;
    checks++; if (bus.Empty !== 1'b1) begin failures++; $display("FAIL overrun_drain_empty got=%b exp=1", bus.Empty); end
    bus.Err_Clr = 1'b1;
    tick();
    bus.Err_Clr = 1'b0;
  endtask

  task automatic test_errors();
    bus.Rx_Error_In = 3'b100;
    tick();
    bus.Rx_Error_In = 3'b000;
    checks++; if (bus.Err_Status !== 4'b0100) begin failures++; $display("FAIL err_set got=%b exp=0100", bus.Err_Status); end
    tick();
    tick();
    checks++; if (bus.Err_Status !== 4'b0100) begin failures++; $display("FAIL err_hold got=%b exp=0100", bus.Err_Status); end
    bus.Err_Clr = 1'b1;
    tick();
    checks++; if (bus.Err_Status !== 4'b0000) begin failures++; $display("FAIL err_clr got=%b exp=0000", bus.Err_Status); end
    bus.Rx_Error_In = 3'b010;
    tick();
    bus.Err_Clr     = 1'b0;
    bus.Rx_Error_In = 3'b000;
    checks++; if (bus.Err_Status !== 4'b0010) begin failures++; $display("FAIL err_set_wins got=%b exp=0010", bus.Err_Status); end
    bus.Err_Clr = 1'b1;
    tick();
    bus.Err_Clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [8:0] d;
    for (int i = 0; i < 6; i++) begin
      d = 9'h040 + 9'(i);
      write_char(d);
    end
    checks++; if (bus.Count !== 5'd6) begin failures++; $display("FAIL mid_pre_count got=%0d exp=6", bus.Count); end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++; if (bus.Count !== 5'd0 || bus.Empty !== 1'b1) begin failures++; $display("FAIL mid_reset got=%0d/%b exp=0/1", bus.Count, bus.Empty); end
    write_char(9'h077);
    bus.Rd_En = 1'b1;
    tick();
    bus.Rd_En = 1'b0;
    checks++; if (bus.Rd_Data !== 9'h077 || bus.Empty !== 1'b1) begin failures++; $display("FAIL mid_read got=%h/%b exp=077/1", bus.Rd_Data, bus.Empty); end
    // level held through reset release is captured once
    bus.Rx_Data_In  = 9'h055;
    bus.Data_Rdy_In = 1'b1;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++; if (bus.Count !== 5'd0) begin failures++; $display("FAIL held_rst_during got=%0d exp=0", bus.Count); end
    tick();
    tick();
    checks++; if (bus.Count !== 5'd1) begin failures++; $display("FAIL held_rst_after got=%0d exp=1", bus.Count); end
    bus.Data_Rdy_In = 1'b0;
    bus.Rd_En = 1'b1;
    tick();
    bus.Rd_En = 1'b0;
    checks++; if (bus.Rd_Data !== 9'h055) begin failures++; $display("FAIL held_rst_data got=%h exp=055", bus.Rd_Data); end
  endtask

  initial begin
    bus.Rx_Data_In  = '0;
    bus.Data_Rdy_In = 1'b0;
    bus.Rx_Error_In = 3'b000;
    bus.Rd_En       = 1'b0;
    bus.Err_Clr     = 1'b0;
    test_reset();
    test_held_level();
    test_fill_wrap();
    test_back_to_back();
    test_overrun();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
